// File: rtl/bcd_step_counter.sv
// Multi-digit BCD up/down counter fed by single-cycle button pulses.
// Each high cycle of inc_pulse or dec_pulse is one step. Carry and borrow ripple
// across all digits combinationally within the cycle.
// The optional macro BCD_STEP_SATURATE_EN makes the counter hold at all-9 and all-0
// instead of wrapping. The wrap flags still pulse in that mode.
module bcd_step_counter #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  inc_pulse,
    input  logic                  dec_pulse,
    input  logic                  clear,
    output logic [4*N_DIGITS-1:0] bcd_value,
    output logic                  zero_flag,
    output logic                  overflow_pulse,
    output logic                  underflow_pulse
);

    localparam int unsigned W = 4 * N_DIGITS;

    // Converts a decimal integer into packed BCD. This runs at elaboration only.
    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] res;
        int unsigned  r;
        res = '0;
        r   = v;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r             = r / 10;
        end
        return res;
    endfunction

    localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_VALUE);

    logic [W-1:0] value_q, value_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic [W-1:0] inc_val, dec_val;
    logic         inc_carry, dec_borrow;
    logic         do_inc, do_dec;

    // Increment with ripple carry. A carry left over at the top means the value was all-9.
    always_comb begin
        inc_val   = value_q;
        inc_carry = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (inc_carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    // Decrement with ripple borrow. A borrow left over at the top means the value was all-0.
    always_comb begin
        dec_val    = value_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (dec_borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    assign do_inc = inc_pulse & ~dec_pulse;
    assign do_dec = dec_pulse & ~inc_pulse;

    // Next state, with priority clear > single step > hold. Flags default low every cycle.
    always_comb begin
        value_d = value_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clear) begin
            value_d = RESET_BCD;
        end else if (do_inc) begin
            ovf_d = inc_carry;
`ifdef BCD_STEP_SATURATE_EN
            value_d = inc_carry ? value_q : inc_val;
`else
            value_d = inc_val;
`endif
        end else if (do_dec) begin
            unf_d = dec_borrow;
`ifdef BCD_STEP_SATURATE_EN
            value_d = dec_borrow ? value_q : dec_val;
`else
            value_d = dec_val;
`endif
        end
    end

    // State register. The synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            value_q <= RESET_BCD;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bcd_value       = value_q;
    assign zero_flag       = (value_q == '0);
    assign overflow_pulse  = ovf_q;
    assign underflow_pulse = unf_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Scoreboard bench for bcd_step_counter with N_DIGITS=4 and RESET_VALUE=1234.
// The expected state comes from an integer model and is pushed at drive time.
// It is popped and compared after the following edge.
module tb_bcd_step_counter;

    localparam int unsigned ND   = 4;
    localparam int unsigned RV   = 1234;
    localparam int          MAXV = 9999;

    logic          clk;
    logic          resetN;
    logic          inc_pulse;
    logic          dec_pulse;
    logic          clear;
    logic [15:0]   bcd_value;
    logic          zero_flag;
    logic          overflow_pulse;
    logic          underflow_pulse;

    bcd_step_counter #(
        .N_DIGITS    (ND),
        .RESET_VALUE (RV)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .inc_pulse       (inc_pulse),
        .dec_pulse       (dec_pulse),
        .clear           (clear),
        .bcd_value       (bcd_value),
        .zero_flag       (zero_flag),
        .overflow_pulse  (overflow_pulse),
        .underflow_pulse (underflow_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] val;
        logic        z;
        logic        o;
        logic        u;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m        = 0;
    logic mo       = 1'b0;
    logic mu       = 1'b0;

    function automatic logic [15:0] dec2bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (model value %0d)", tag, got, exp, m);
        end
    endtask

    // One clock: drive inputs, advance the model, push the expectation, then compare.
    task automatic step(input logic rst_n, input logic inc, input logic dec, input logic clr);
        exp_t e;
        @(negedge clk);
        resetN    = rst_n;
        inc_pulse = inc;
        dec_pulse = dec;
        clear     = clr;
        mo = 1'b0;
        mu = 1'b0;
        if (!rst_n) begin
            m = RV;
        end else if (clr) begin
            m = RV;
        end else if (inc && !dec) begin
            if (m == MAXV) begin
                mo = 1'b1;
`ifdef BCD_STEP_SATURATE_EN
                m = MAXV;
`else
                m = 0;
`endif
            end else begin
                m = m + 1;
            end
        end else if (dec && !inc) begin
            if (m == 0) begin
                mu = 1'b1;
`ifdef BCD_STEP_SATURATE_EN
                m = 0;
`else
                m = MAXV;
`endif
            end else begin
                m = m - 1;
            end
        end
        e.val = dec2bcd(m);
        e.z   = (m == 0);
        e.o   = mo;
        e.u   = mu;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("bcd_value", 32'(bcd_value), 32'(e.val));
        check("zero_flag", 32'(zero_flag), 32'(e.z));
        check("overflow_pulse", 32'(overflow_pulse), 32'(e.o));
        check("underflow_pulse", 32'(underflow_pulse), 32'(e.u));
    endtask

    task automatic goto_value(input int target);
        while (m != target) begin
            if (m < target) step(1'b1, 1'b1, 1'b0, 1'b0);
            else            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        clear     = 1'b0;

        // Reset held for two cycles, with a pulse present that must be discarded.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Step up to 1240, then clear.
        goto_value(1240);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Carry into the hundreds digit, then borrow out of the thousands digit.
        goto_value(199);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        goto_value(1000);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Twelve increments on back-to-back cycles, starting from zero.
        goto_value(0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Simultaneous inc and dec net to zero. Clear beats a concurrent increment.
        goto_value(500);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Wrapping or saturating at the extremes, including consecutive flag cycles.
        goto_value(MAXV);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        goto_value(0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // A reset in mid-stream, followed by the first count after release.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
